// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order fetch requests, response
// buffering into a small circular FIFO, and delivery to decode until the last instruction.
module fetch_unit #(
  parameter int PC_BIT      = 8,
  parameter int INST_ID_BIT = 8,
  parameter int OP_BIT      = 3,
  parameter int TAG_ID_BIT  = 2,
  parameter int IMM_BIT     = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fetch_vld,
  input  logic                   fetch_rdy,
  output logic [PC_BIT-1:0]      fetch_pc,
  output logic [INST_ID_BIT-1:0] fetch_id,
  input  logic                   inst_vld,
  output logic                   inst_rdy,
  input  logic [INST_ID_BIT-1:0] inst_id,
  input  logic                   inst_last,
  input  logic [OP_BIT-1:0]      inst_op,
  input  logic [TAG_ID_BIT-1:0]  inst_dst_reg,
  input  logic [TAG_ID_BIT-1:0]  inst_src_reg1,
  input  logic [TAG_ID_BIT-1:0]  inst_src_reg0,
  input  logic [IMM_BIT-1:0]     inst_imm,
  output logic                   dec_vld,
  input  logic                   dec_rdy,
  output logic [INST_ID_BIT-1:0] dec_id,
  output logic [OP_BIT-1:0]      dec_op,
  output logic [TAG_ID_BIT-1:0]  dec_dst_reg,
  output logic [TAG_ID_BIT-1:0]  dec_src_reg1,
  output logic [TAG_ID_BIT-1:0]  dec_src_reg0,
  output logic [IMM_BIT-1:0]     dec_imm,
  output logic                   dec_last,
  output logic                   fetch_done,
  output logic                   id_err
);

  localparam int CNT_BIT   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_BIT   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_BIT = INST_ID_BIT + OP_BIT + 3 * TAG_ID_BIT + IMM_BIT + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t               state, state_next;
  logic                 active;
  logic [CNT_BIT-1:0]   fifo_cnt, outstanding;
  logic [CNT_BIT:0]     credit_used;
  logic [PTR_BIT-1:0]   rd_ptr, wr_ptr;
  logic [INST_ID_BIT-1:0] exp_id;
  logic [ENTRY_BIT-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_BIT-1:0] head;
  logic                 fifo_full, fetch_hs, resp_hs, push, pop;

  // active holds every handshake output low during reset and until the first clock after release
  assign fifo_full   = (fifo_cnt == CNT_BIT'(FIFO_DEPTH));
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, outstanding};
  assign fetch_vld   = active && (state == RUN) && (credit_used < (CNT_BIT + 1)'(FIFO_DEPTH));
  assign inst_rdy    = active && !fifo_full;
  assign dec_vld     = (fifo_cnt != '0);
  assign fetch_done  = (state == DONE);

  assign fetch_hs = fetch_vld && fetch_rdy;
  assign resp_hs  = inst_vld && inst_rdy;
  assign push     = resp_hs && (state == RUN);
  assign pop      = dec_vld && dec_rdy;

  assign head = dec_vld ? mem[rd_ptr] : '0;
  assign {dec_id, dec_op, dec_dst_reg, dec_src_reg1, dec_src_reg0, dec_imm, dec_last} = head;

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (push && inst_last) state_next = DRAIN;
      DRAIN:   if (outstanding == '0 && fifo_cnt == '0) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      active      <= 1'b0;
      fetch_pc    <= '0;
      fetch_id    <= '0;
      outstanding <= '0;
      fifo_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      exp_id      <= '0;
      id_err      <= 1'b0;
    end else begin
      active <= 1'b1;
      state  <= state_next;
      if (fetch_hs) begin
        fetch_pc <= fetch_pc + 1'b1;
        fetch_id <= fetch_id + 1'b1;
      end
      if (fetch_hs && !resp_hs)
        outstanding <= outstanding + 1'b1;
      else if (!fetch_hs && resp_hs)
        outstanding <= outstanding - 1'b1;
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_BIT'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        exp_id <= exp_id + 1'b1;
        if (inst_id != exp_id) id_err <= 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_BIT'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop)
        fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Storage needs no reset: entries are only observable through the count-gated head
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {inst_id, inst_op, inst_dst_reg, inst_src_reg1, inst_src_reg0, inst_imm, inst_last};
  end

endmodule
